// File: rtl/draw_image_blitter.sv
// draw_image_blitter
//   Walks an IMG_W x IMG_H image stored row-major in an external synchronous
//   ROM and issues one VGA plot request per pixel, offset by a run-time
//   origin. Pixels that land off-screen or that match the transparent key
//   are suppressed, but x/y/colour still update for them.
//
// Ports
//   clk        clock
//   resetn     synchronous active-low reset
//   start      begin a blit (sampled only while idle)
//   base_addr  ROM address of pixel (0,0), latched on accepted start
//   origin_x   screen x of pixel (0,0), latched on accepted start
//   origin_y   screen y of pixel (0,0), latched on accepted start
//   busy       high while addresses are issued or the ROM pipeline drains
//   done       one-cycle completion pulse
//   rom_addr   registered ROM address
//   rom_data   ROM output, ROM_LATENCY cycles after rom_addr
//   plot       VGA write enable
//   x, y       pixel coordinates to VGA
//   colour     pixel colour (rom_data passthrough)
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for start
// RUN   | one ROM address issued per cycle, pixel 0 .. N-1
// DRAIN | ROM_LATENCY cycles letting the last pixels leave the ROM
// DONE  | done pulse, then back to IDLE

module draw_image_blitter #(
    parameter int IMG_W       = 80,
    parameter int IMG_H       = 40,
    parameter int ADDR_W      = 12,
    parameter int COLOUR_W    = 9,
    parameter int X_W         = 8,
    parameter int Y_W         = 7,
    parameter int SCREEN_W    = 160,
    parameter int SCREEN_H    = 120,
    parameter int ROM_LATENCY = 1,
    parameter bit TRANSP_EN   = 1'b1,
    parameter logic [COLOUR_W-1:0] TRANSP_KEY = '0
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [X_W-1:0]      origin_x,
    input  logic [Y_W-1:0]      origin_y,
    output logic                busy,
    output logic                done,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [COLOUR_W-1:0] rom_data,
    output logic                plot,
    output logic [X_W-1:0]      x,
    output logic [Y_W-1:0]      y,
    output logic [COLOUR_W-1:0] colour
);

    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMG_H - 1);
    localparam logic [X_W:0]     SCR_W_LIM  = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]     SCR_H_LIM  = (Y_W+1)'(SCREEN_H);
    localparam logic [1:0]       DRAIN_LOAD = 2'(ROM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // One entry per ROM pipeline stage; the origin add happens before the
    // delay line so the last stage feeds x/y straight from flops.
    typedef struct packed {
        logic           valid;
        logic           in_bounds;
        logic [X_W-1:0] px;
        logic [Y_W-1:0] py;
    } tag_t;

    state_t           state_q;
    state_t           state_d;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [X_W-1:0]   org_x;
    logic [Y_W-1:0]   org_y;
    logic [1:0]       drain_cnt;
    logic             last_px;
    logic [X_W:0]     x_sum;
    logic [Y_W:0]     y_sum;
    tag_t             tag_in;
    tag_t             dl [ROM_LATENCY];
    logic             key_hit;

    assign last_px = (col == COL_LAST) && (row == ROW_LAST);

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)            state_d = S_RUN;
            S_RUN:   if (last_px)          state_d = S_DRAIN;
            S_DRAIN: if (drain_cnt == 2'd0) state_d = S_DONE;
            S_DONE:                        state_d = S_IDLE;
            default:                       state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

    // ---------------------------------------------------------------
    // Address walk: col/row always describe the pixel at rom_addr.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rom_addr  <= '0;
            col       <= '0;
            row       <= '0;
            org_x     <= '0;
            org_y     <= '0;
            drain_cnt <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        rom_addr <= base_addr;
                        org_x    <= origin_x;
                        org_y    <= origin_y;
                        col      <= '0;
                        row      <= '0;
                    end
                end
                S_RUN: begin
                    if (last_px) begin
                        drain_cnt <= DRAIN_LOAD;
                    end else begin
                        rom_addr <= rom_addr + 1'b1;
                        if (col == COL_LAST) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt != 2'd0) begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------
    // Screen position and clip test, one bit wider so wrap-around past
    // the top of the coordinate range still counts as off-screen.
    // ---------------------------------------------------------------
    assign x_sum = {1'b0, org_x} + (X_W+1)'(col);
    assign y_sum = {1'b0, org_y} + (Y_W+1)'(row);

    always_comb begin
        tag_in           = '0;
        tag_in.valid     = (state_q == S_RUN);
        tag_in.in_bounds = (x_sum < SCR_W_LIM) && (y_sum < SCR_H_LIM);
        tag_in.px        = x_sum[X_W-1:0];
        tag_in.py        = y_sum[Y_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < ROM_LATENCY; i++) begin
                dl[i] <= '0;
            end
        end else begin
            dl[0] <= tag_in;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                dl[i] <= dl[i-1];
            end
        end
    end

    // ---------------------------------------------------------------
    // Outputs: the last delay stage lines up with rom_data.
    // ---------------------------------------------------------------
    assign key_hit = TRANSP_EN && (rom_data == TRANSP_KEY);
    assign plot    = dl[ROM_LATENCY-1].valid && dl[ROM_LATENCY-1].in_bounds && !key_hit;
    assign x       = dl[ROM_LATENCY-1].px;
    assign y       = dl[ROM_LATENCY-1].py;
    assign colour  = rom_data;

endmodule
